// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the combinational
// instruction memory and captures the returned word into IF/ID.
// Optional feature macro: FETCH_HALT_EN (halt on HALT_INST capture).
module fetch_stage #(
  parameter int unsigned       ADDR_W    = 12,
  parameter int unsigned       INST_W    = 19,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [INST_W-1:0] NOP_INST  = '0,
  parameter logic [INST_W-1:0] HALT_INST = '1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic [INST_W-1:0] imem_data_i,
  output logic [INST_W-1:0] ifid_inst_o,
  output logic [ADDR_W-1:0] ifid_pc_next_o,
  output logic              ifid_valid_o,
  output logic              halted_o
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [INST_W-1:0] ifid_inst_q, ifid_inst_d;
  logic [ADDR_W-1:0] ifid_pc_next_q, ifid_pc_next_d;
  logic              ifid_valid_q, ifid_valid_d;
  logic [ADDR_W-1:0] pc_inc;
  logic              halted_q;

  // PC+1 wraps naturally at 2^ADDR_W
  assign pc_inc = pc_q + ADDR_W'(1);

`ifdef FETCH_HALT_EN
  logic halted_d;

  // Halt sets when a real capture loads HALT_INST; rst or redirect clears it
  always_comb begin
    halted_d = halted_q;
    if (rst_i || redirect_i) begin
      halted_d = 1'b0;
    end else if (!flush_i && !stall_i && !halted_q && (imem_data_i == HALT_INST)) begin
      halted_d = 1'b1;
    end
  end

  // Halt state register
  always_ff @(posedge clk_i) begin
    halted_q <= halted_d;
  end
`else
  // Without the halt feature HALT_INST is an ordinary instruction
  assign halted_q = 1'b0;
`endif

  // PC next-state: rst > redirect (even under stall) > stall/halted hold > increment
  always_comb begin
    pc_d = pc_inc;
    if (rst_i) begin
      pc_d = RESET_PC;
    end else if (redirect_i) begin
      pc_d = redirect_pc_i;
    end else if (stall_i || halted_q) begin
      pc_d = pc_q;
    end
  end

  // IF/ID next-state: rst/flush bubble > stall hold > halted bubble > capture.
  // A redirect without flush still captures the old-PC word (delay slot).
  always_comb begin
    ifid_inst_d    = imem_data_i;
    ifid_pc_next_d = pc_inc;
    ifid_valid_d   = 1'b1;
    if (rst_i || flush_i || (!stall_i && halted_q)) begin
      ifid_inst_d    = NOP_INST;
      ifid_pc_next_d = '0;
      ifid_valid_d   = 1'b0;
    end else if (stall_i) begin
      ifid_inst_d    = ifid_inst_q;
      ifid_pc_next_d = ifid_pc_next_q;
      ifid_valid_d   = ifid_valid_q;
    end
  end

  // PC and IF/ID registers; reset is folded into the next-state logic
  always_ff @(posedge clk_i) begin
    pc_q           <= pc_d;
    ifid_inst_q    <= ifid_inst_d;
    ifid_pc_next_q <= ifid_pc_next_d;
    ifid_valid_q   <= ifid_valid_d;
  end

  assign imem_addr_o    = pc_q;
  assign ifid_inst_o    = ifid_inst_q;
  assign ifid_pc_next_o = ifid_pc_next_q;
  assign ifid_valid_o   = ifid_valid_q;
  assign halted_o       = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: expected IF/ID contents are pushed to a queue as
// each cycle's controls are driven and popped after the clock edge.
module tb_fetch_stage;

  localparam logic [18:0] NOP  = 19'd0;
  localparam logic [18:0] HALT = 19'h7FFFF;

  typedef struct packed {
    logic [18:0] inst;
    logic [11:0] pc_next;
    logic        valid;
    logic        halted;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, stall, flush, redirect;
  logic [11:0] redirect_pc;
  logic [11:0] imem_addr;
  logic [18:0] imem_data;
  logic [18:0] ifid_inst;
  logic [11:0] ifid_pc_next;
  logic        ifid_valid, halted;

  logic [11:0] w_addr, w_pc_next;
  logic [18:0] w_data, w_inst;
  logic        w_valid, w_halted;

  logic        halt_mem = 1'b0;
  int          n_checks = 0;
  int          n_pass   = 0;

  exp_t        sb_q[$];
  exp_t        m_ifid;
  logic [11:0] m_pc;
  logic        m_halted;

  always #5 clk = ~clk;

  fetch_stage u_dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .imem_addr_o(imem_addr), .imem_data_i(imem_data),
    .ifid_inst_o(ifid_inst), .ifid_pc_next_o(ifid_pc_next),
    .ifid_valid_o(ifid_valid), .halted_o(halted)
  );

  fetch_stage #(.RESET_PC(12'd4094)) u_wrap (
    .clk_i(clk), .rst_i(rst), .stall_i(1'b0), .flush_i(1'b0),
    .redirect_i(1'b0), .redirect_pc_i(12'd0),
    .imem_addr_o(w_addr), .imem_data_i(w_data),
    .ifid_inst_o(w_inst), .ifid_pc_next_o(w_pc_next),
    .ifid_valid_o(w_valid), .halted_o(w_halted)
  );

  function automatic logic [18:0] mem_f(input logic [11:0] a, input logic hm);
    if (hm && a == 12'd3) return HALT;
    return {7'd0, a} + 19'd100;
  endfunction

  always_comb imem_data = mem_f(imem_addr, halt_mem);
  always_comb w_data    = mem_f(w_addr, 1'b0);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // One cycle: check PC, drive controls, predict IF/ID, clock, compare.
  task automatic step(input logic r, input logic s, input logic f,
                      input logic rd, input logic [11:0] rpc);
    exp_t        e, got_e;
    logic [18:0] word;
    logic [11:0] nxt;
    check("imem_addr", {20'd0, imem_addr}, {20'd0, m_pc});
    rst = r; stall = s; flush = f; redirect = rd; redirect_pc = rpc;
    word = mem_f(m_pc, halt_mem);
    if (r || f)        e = '{inst: NOP, pc_next: 12'd0, valid: 1'b0, halted: 1'b0};
    else if (s)        e = m_ifid;
    else if (m_halted) e = '{inst: NOP, pc_next: 12'd0, valid: 1'b0, halted: 1'b0};
    else               e = '{inst: word, pc_next: m_pc + 12'd1, valid: 1'b1, halted: 1'b0};
`ifdef FETCH_HALT_EN
    if (r || rd) e.halted = 1'b0;
    else if (!f && !s && !m_halted && word == HALT) e.halted = 1'b1;
    else e.halted = m_halted;
`endif
    if (r)                  nxt = 12'd0;
    else if (rd)            nxt = rpc;
    else if (s || m_halted) nxt = m_pc;
    else                    nxt = m_pc + 12'd1;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    got_e = sb_q.pop_front();
    check("ifid_inst",    {13'd0, ifid_inst},    {13'd0, got_e.inst});
    check("ifid_pc_next", {20'd0, ifid_pc_next}, {20'd0, got_e.pc_next});
    check("ifid_valid",   {31'd0, ifid_valid},   {31'd0, got_e.valid});
    check("halted",       {31'd0, halted},       {31'd0, got_e.halted});
    m_ifid   = got_e;
    m_halted = got_e.halted;
    m_pc     = nxt;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = 12'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst imem_addr",    {20'd0, imem_addr},    32'd0);
    check("rst ifid_inst",    {13'd0, ifid_inst},    32'd0);
    check("rst ifid_pc_next", {20'd0, ifid_pc_next}, 32'd0);
    check("rst ifid_valid",   {31'd0, ifid_valid},   32'd0);
    check("rst halted",       {31'd0, halted},       32'd0);
    check("rst wrap addr",    {20'd0, w_addr},       32'd4094);
    m_pc = 12'd0; m_halted = 1'b0;
    m_ifid = '{inst: NOP, pc_next: 12'd0, valid: 1'b0, halted: 1'b0};

    // free run, with the wrap instance checked alongside
    step(0, 0, 0, 0, 12'd0);
    check("wrap addr 4095",  {20'd0, w_addr},    32'd4095);
    check("wrap pcn 4095",   {20'd0, w_pc_next}, 32'd4095);
    step(0, 0, 0, 0, 12'd0);
    check("wrap addr 0",     {20'd0, w_addr},    32'd0);
    check("wrap pcn 0",      {20'd0, w_pc_next}, 32'd0);
    check("wrap inst 4095",  {13'd0, w_inst},    32'd4195);
    step(0, 0, 0, 0, 12'd0);
    check("wrap pcn 1",      {20'd0, w_pc_next}, 32'd1);
    step(0, 0, 0, 0, 12'd0);
    step(0, 0, 0, 0, 12'd0);          // captures word 4, PC = 5
    check("pc before stall", {20'd0, imem_addr}, 32'd5);

    step(0, 1, 0, 0, 12'd0);          // stall 2 cycles at PC 5
    step(0, 1, 0, 0, 12'd0);
    check("stall ifid word4", {13'd0, ifid_inst}, 32'd104);
    step(0, 0, 0, 0, 12'd0);          // word 5, pc_next 6
    step(0, 0, 0, 0, 12'd0);          // PC = 7

    step(0, 0, 1, 1, 12'd40);         // redirect+flush -> bubble, PC 40
    step(0, 0, 0, 0, 12'd0);          // word 40, pc_next 41
    check("after redirect", {13'd0, ifid_inst}, 32'd140);

    step(0, 0, 1, 1, 12'd9);          // move to PC 9
    step(0, 0, 0, 1, 12'd20);         // delay slot: word 9 valid, PC 20
    step(0, 0, 0, 0, 12'd0);          // word 20

    step(0, 1, 1, 0, 12'd0);          // flush beats stall, PC holds
    step(0, 1, 0, 1, 12'd300);        // redirect under stall, IF/ID holds
    step(0, 0, 0, 0, 12'd0);
    step(1, 1, 1, 1, 12'd77);         // reset overrides everything

    halt_mem = 1'b1;                  // HALT_INST placed at address 3
    repeat (4) step(0, 0, 0, 0, 12'd0);
    step(0, 0, 0, 0, 12'd0);
    step(0, 0, 0, 0, 12'd0);
`ifdef FETCH_HALT_EN
    check("halt pc frozen", {20'd0, imem_addr}, 32'd4);
    check("halt held",      {31'd0, halted},    32'd1);
`else
    check("no-halt pc",     {20'd0, imem_addr}, 32'd6);
`endif
    step(0, 0, 0, 1, 12'd0);          // redirect resumes fetch at 0
    check("resume halted",  {31'd0, halted},    32'd0);
    step(0, 0, 0, 0, 12'd0);
    step(0, 0, 0, 0, 12'd0);
    step(0, 0, 0, 0, 12'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
